// File: rtl/cfg_chain_pkg.sv
// Shared types and constants for the configuration chain loader.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
//
// Contents: load FSM state enum, CRC-16-CCITT constants and a one-bit CRC step.
package cfg_chain_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // One MSB-first CRC-16 step over a single input bit.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/cfg_chain_lane.sv
// One configuration chain: shift register, shadow (committed) register and tail flop.
// Latency: tail_bit and the shift contents update 1 cycle after shift_en; shadow 1 cycle after commit_en.
// Backpressure: none locally; the parent only raises shift_en on an accepted beat.
//
// Ports:
//   prog_clk, reset      clock and synchronous active-high reset
//   shift_en             accept head_bit into the LSB, pushing the MSB out to tail_bit
//   commit_en            copy the shift register into the shadow register
//   head_bit             incoming configuration bit
//   tail_bit             bit shifted out of the MSB (pre-shift value), registered
//   shadow               committed configuration bits for this chain
module cfg_chain_lane #(
  parameter int CHAIN_LEN = 64
) (
  input  logic                 prog_clk,
  input  logic                 reset,
  input  logic                 shift_en,
  input  logic                 commit_en,
  input  logic                 head_bit,
  output logic                 tail_bit,
  output logic [CHAIN_LEN-1:0] shadow
);

  logic [CHAIN_LEN-1:0] shift_q, shift_d;
  logic [CHAIN_LEN-1:0] shadow_q, shadow_d;
  logic                 tail_q, tail_d;

  always_comb begin
    shift_d  = shift_q;
    tail_d   = tail_q;
    shadow_d = shadow_q;
    if (shift_en) begin
      shift_d = {shift_q[CHAIN_LEN-2:0], head_bit};
      tail_d  = shift_q[CHAIN_LEN-1];
    end
    if (commit_en) begin
      shadow_d = shift_q;
    end
  end

  always_ff @(posedge prog_clk) begin
    if (reset) begin
      shift_q  <= '0;
      shadow_q <= '0;
      tail_q   <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      shadow_q <= shadow_d;
      tail_q   <= tail_d;
    end
  end

  assign tail_bit = tail_q;
  assign shadow   = shadow_q;

endmodule

// File: rtl/cfg_chain_loader.sv
// Loads a bitstream into NUM_CHAINS parallel config chains and commits it atomically to a shadow image.
// Latency: fpga_tail/tail_valid 1 cycle after an accepted beat; cfg_out/cfg_done 2 cycles after the final beat.
// Backpressure: head_ready is high only in SHIFT with no abort pending; beats are taken on head_valid & head_ready.
//
// Ports:
//   prog_clk, reset    clock and synchronous active-high reset
//   cfg_start          begin a load (honoured in IDLE only, and not together with cfg_abort)
//   cfg_abort          abandon the load in SHIFT without committing
//   fpga_head          one head bit per chain; head_valid qualifies it, head_ready accepts it
//   fpga_tail          bits shifted out of each chain MSB, tail_valid marks a new beat
//   cfg_busy           high in SHIFT and COMMIT
//   cfg_done           one-cycle pulse in the first cycle of the new cfg_out
//   cfg_out            committed config, chain c at [c*CHAIN_LEN +: CHAIN_LEN]
//   crc_out            CRC-16-CCITT of all accepted bits (only with CFG_CHAIN_CRC_EN defined)
module cfg_chain_loader
  import cfg_chain_pkg::*;
#(
  parameter int NUM_CHAINS = 4,
  parameter int CHAIN_LEN  = 64,
  parameter int CNT_W      = (CHAIN_LEN > 2) ? $clog2(CHAIN_LEN) : 1
) (
  input  logic                            prog_clk,
  input  logic                            reset,
  input  logic                            cfg_start,
  input  logic                            cfg_abort,
  input  logic [NUM_CHAINS-1:0]           fpga_head,
  input  logic                            head_valid,
  output logic                            head_ready,
  output logic [NUM_CHAINS-1:0]           fpga_tail,
  output logic                            tail_valid,
  output logic                            cfg_busy,
  output logic                            cfg_done,
  output logic [NUM_CHAINS*CHAIN_LEN-1:0] cfg_out
`ifdef CFG_CHAIN_CRC_EN
  ,
  output logic [15:0]                     crc_out
`endif
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(CHAIN_LEN - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tail_valid_q, tail_valid_d;
  logic             cfg_done_q, cfg_done_d;
  logic             head_ready_c;
  logic             shift_en;
  logic             commit_en;

`ifdef CFG_CHAIN_CRC_EN
  logic [15:0] crc_q, crc_d;
  logic [15:0] crc_beat;

  // Chain 0 is the first bit of each beat into the CRC.
  always_comb begin
    crc_beat = crc_q;
    for (int c = 0; c < NUM_CHAINS; c++) begin
      crc_beat = crc16_step(crc_beat, fpga_head[c]);
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tail_valid_d = 1'b0;
    cfg_done_d   = 1'b0;
    head_ready_c = 1'b0;
`ifdef CFG_CHAIN_CRC_EN
    crc_d        = crc_q;
`endif
    case (state_q)
      IDLE: begin
        if (cfg_start && !cfg_abort) begin
          state_d = SHIFT;
          cnt_d   = '0;
`ifdef CFG_CHAIN_CRC_EN
          crc_d   = CRC_INIT;
`endif
        end
      end
      SHIFT: begin
        // An abort cycle never accepts a beat, so the chains keep their contents.
        if (cfg_abort) begin
          state_d = IDLE;
        end else begin
          head_ready_c = 1'b1;
          if (head_valid) begin
            tail_valid_d = 1'b1;
`ifdef CFG_CHAIN_CRC_EN
            crc_d        = crc_beat;
`endif
            if (cnt_q == LAST_BEAT) begin
              cnt_d   = '0;
              state_d = COMMIT;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      end
      COMMIT: begin
        state_d    = IDLE;
        cfg_done_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign shift_en  = head_valid & head_ready_c;
  assign commit_en = (state_q == COMMIT);

  always_ff @(posedge prog_clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      tail_valid_q <= 1'b0;
      cfg_done_q   <= 1'b0;
`ifdef CFG_CHAIN_CRC_EN
      crc_q        <= CRC_INIT;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tail_valid_q <= tail_valid_d;
      cfg_done_q   <= cfg_done_d;
`ifdef CFG_CHAIN_CRC_EN
      crc_q        <= crc_d;
`endif
    end
  end

  for (genvar c = 0; c < NUM_CHAINS; c++) begin : g_lane
    cfg_chain_lane #(
      .CHAIN_LEN(CHAIN_LEN)
    ) u_lane (
      .prog_clk (prog_clk),
      .reset    (reset),
      .shift_en (shift_en),
      .commit_en(commit_en),
      .head_bit (fpga_head[c]),
      .tail_bit (fpga_tail[c]),
      .shadow   (cfg_out[c*CHAIN_LEN +: CHAIN_LEN])
    );
  end

  assign head_ready = head_ready_c;
  assign tail_valid = tail_valid_q;
  assign cfg_done   = cfg_done_q;
  assign cfg_busy   = (state_q != IDLE);
`ifdef CFG_CHAIN_CRC_EN
  assign crc_out    = crc_q;
`endif

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Directed bench for cfg_chain_loader with NUM_CHAINS=2, CHAIN_LEN=8.
// Latency: inputs driven 1 time unit after the rising edge, registered outputs sampled there too.
// Backpressure: head_ready checked combinationally before each edge.
module tb_cfg_chain_loader;

  localparam int NC = 2;
  localparam int CL = 8;

  logic          prog_clk = 1'b0;
  logic          reset;
  logic          cfg_start;
  logic          cfg_abort;
  logic [NC-1:0] fpga_head;
  logic          head_valid;
  logic          head_ready;
  logic [NC-1:0] fpga_tail;
  logic          tail_valid;
  logic          cfg_busy;
  logic          cfg_done;
  logic [NC*CL-1:0] cfg_out;
`ifdef CFG_CHAIN_CRC_EN
  logic [15:0]   crc_out;
  logic          s_ready, s_tail, s_tvld, s_busy, s_done;
  logic [CL-1:0] s_out;
  logic [15:0]   s_crc;
`endif

  always #5 prog_clk = ~prog_clk;

  cfg_chain_loader #(.NUM_CHAINS(NC), .CHAIN_LEN(CL)) dut (
    .prog_clk  (prog_clk),
    .reset     (reset),
    .cfg_start (cfg_start),
    .cfg_abort (cfg_abort),
    .fpga_head (fpga_head),
    .head_valid(head_valid),
    .head_ready(head_ready),
    .fpga_tail (fpga_tail),
    .tail_valid(tail_valid),
    .cfg_busy  (cfg_busy),
    .cfg_done  (cfg_done),
    .cfg_out   (cfg_out)
`ifdef CFG_CHAIN_CRC_EN
    ,
    .crc_out   (crc_out)
`endif
  );

`ifdef CFG_CHAIN_CRC_EN
  // Single-chain instance sharing the control inputs, fed chain 0's bits.
  cfg_chain_loader #(.NUM_CHAINS(1), .CHAIN_LEN(CL)) dut_crc (
    .prog_clk  (prog_clk),
    .reset     (reset),
    .cfg_start (cfg_start),
    .cfg_abort (cfg_abort),
    .fpga_head (fpga_head[0:0]),
    .head_valid(head_valid),
    .head_ready(s_ready),
    .fpga_tail (s_tail),
    .tail_valid(s_tvld),
    .cfg_busy  (s_busy),
    .cfg_done  (s_done),
    .cfg_out   (s_out),
    .crc_out   (s_crc)
  );
`endif

  typedef struct {
    logic          start;
    logic          abort;
    logic          valid;
    logic [NC-1:0] head;
    logic          exp_rdy;
    logic          exp_tvld;
    logic [NC-1:0] exp_tail;
    logic          exp_done;
    logic          exp_busy;
    logic [NC*CL-1:0] exp_out;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [7:0] PAT0 = 8'b1011_0010;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic add(input logic s, input logic a, input logic v, input logic [NC-1:0] h,
                     input logic rdy, input logic tv, input logic [NC-1:0] t,
                     input logic d, input logic b, input logic [NC*CL-1:0] o);
    vec_t x;
    x.start = s; x.abort = a; x.valid = v; x.head = h;
    x.exp_rdy = rdy; x.exp_tvld = tv; x.exp_tail = t;
    x.exp_done = d; x.exp_busy = b; x.exp_out = o;
    vecs.push_back(x);
  endtask

  task automatic drive_idle();
    cfg_start = 1'b0; cfg_abort = 1'b0; head_valid = 1'b0; fpga_head = '0;
  endtask

  initial begin
    logic [7:0] pat;
    int beats;
    logic acc;

    pat = PAT0;
    reset = 1'b1;
    drive_idle();

    // Load 1: chain0 gets 1,0,1,1,0,0,1,0; chain1 all ones; shift regs start at zero.
    add(1, 0, 0, 2'b00, 0, 0, 2'b00, 0, 1, 16'h0000);
    for (int k = 0; k < CL; k++)
      add(0, 0, 1, {1'b1, pat[7-k]}, 1, 1, 2'b00, 0, 1, 16'h0000);
    add(0, 0, 0, 2'b00, 0, 0, 2'b00, 1, 0, 16'hFFB2);
    // Start again in the cfg_done cycle; load 2 is all zeros and pushes load 1 out of the tails.
    add(1, 0, 0, 2'b00, 0, 0, 2'b00, 0, 1, 16'hFFB2);
    for (int k = 0; k < CL; k++)
      add(0, 0, 1, 2'b00, 1, 1, {1'b1, pat[7-k]}, 0, 1, 16'hFFB2);
    add(0, 0, 0, 2'b00, 0, 0, 2'b10, 1, 0, 16'h0000);
    add(0, 0, 0, 2'b00, 0, 0, 2'b10, 0, 0, 16'h0000);

    repeat (2) tick();
    chk("rst_busy", 32'(cfg_busy), 32'd0);
    chk("rst_done", 32'(cfg_done), 32'd0);
    chk("rst_tvld", 32'(tail_valid), 32'd0);
    chk("rst_tail", 32'(fpga_tail), 32'd0);
    chk("rst_out", 32'(cfg_out), 32'd0);
    reset = 1'b0;
    head_valid = 1'b1;
    #1;
    chk("rst_rdy_idle", 32'(head_ready), 32'd0);
    drive_idle();
    tick();

    foreach (vecs[i]) begin
      cfg_start  = vecs[i].start;
      cfg_abort  = vecs[i].abort;
      head_valid = vecs[i].valid;
      fpga_head  = vecs[i].head;
      #1;
      chk($sformatf("v%0d_rdy", i), 32'(head_ready), 32'(vecs[i].exp_rdy));
      tick();
      chk($sformatf("v%0d_tvld", i), 32'(tail_valid), 32'(vecs[i].exp_tvld));
      chk($sformatf("v%0d_tail", i), 32'(fpga_tail), 32'(vecs[i].exp_tail));
      chk($sformatf("v%0d_done", i), 32'(cfg_done), 32'(vecs[i].exp_done));
      chk($sformatf("v%0d_busy", i), 32'(cfg_busy), 32'(vecs[i].exp_busy));
      chk($sformatf("v%0d_out", i), 32'(cfg_out), 32'(vecs[i].exp_out));
    end
`ifdef CFG_CHAIN_CRC_EN
    chk("crc_zero_byte", 32'(s_crc), 32'h0000E1F0);
`endif

    // head_valid toggling: only valid cycles are beats, tail_valid follows each by one cycle.
    drive_idle();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("tog_busy", 32'(cfg_busy), 32'd1);
    beats = 0;
    for (int cyc = 0; cyc < 40 && beats < CL; cyc++) begin
      head_valid = (cyc % 2 == 0);
      fpga_head  = {1'b1, pat[7-beats]};
      #1;
      chk("tog_rdy", 32'(head_ready), 32'd1);
      acc = head_valid;
      tick();
      if (acc) beats++;
      chk("tog_tvld", 32'(tail_valid), 32'(acc));
      chk("tog_tail", 32'(fpga_tail), 32'd0);
    end
    chk("tog_beats", 32'(beats), 32'd8);
    head_valid = 1'b1;
    fpga_head  = 2'b11;
    #1;
    chk("tog_commit_rdy", 32'(head_ready), 32'd0);
    tick();
    chk("tog_commit_tvld", 32'(tail_valid), 32'd0);
    chk("tog_done", 32'(cfg_done), 32'd1);
    chk("tog_out", 32'(cfg_out), 32'h0000FFB2);
    drive_idle();
    tick();
    chk("tog_done_end", 32'(cfg_done), 32'd0);
    chk("tog_busy_end", 32'(cfg_busy), 32'd0);

    // Abort after beat 5: no commit, shadow untouched.
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    head_valid = 1'b1;
    fpga_head  = 2'b00;
    repeat (5) tick();
    cfg_abort = 1'b1;
    #1;
    chk("abt_rdy", 32'(head_ready), 32'd0);
    tick();
    chk("abt_busy", 32'(cfg_busy), 32'd0);
    chk("abt_tvld", 32'(tail_valid), 32'd0);
    chk("abt_done", 32'(cfg_done), 32'd0);
    chk("abt_out", 32'(cfg_out), 32'h0000FFB2);
    drive_idle();
    tick();
    chk("abt_done_later", 32'(cfg_done), 32'd0);
    cfg_start = 1'b1;
    cfg_abort = 1'b1;
    tick();
    chk("start_abort_idle", 32'(cfg_busy), 32'd0);
    drive_idle();
    tick();
    chk("start_abort_idle2", 32'(cfg_busy), 32'd0);

    // Reset during beat 4. Chains hold 0x40/0xE0 after the abort, so beat 3 emits tail 2'b10.
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    head_valid = 1'b1;
    repeat (3) tick();
    chk("pre_rst_tail", 32'(fpga_tail), 32'd2);
    reset = 1'b1;
    tick();
    chk("mid_rst_tail", 32'(fpga_tail), 32'd0);
    chk("mid_rst_tvld", 32'(tail_valid), 32'd0);
    chk("mid_rst_out", 32'(cfg_out), 32'd0);
    chk("mid_rst_busy", 32'(cfg_busy), 32'd0);
    chk("mid_rst_done", 32'(cfg_done), 32'd0);
    reset = 1'b0;
    drive_idle();
    tick();
    chk("post_rst_done", 32'(cfg_done), 32'd0);

    // Full load after reset completes normally.
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    head_valid = 1'b1;
    for (int k = 0; k < CL; k++) begin
      fpga_head = {1'b1, pat[7-k]};
      tick();
    end
    drive_idle();
    chk("rl_out_before", 32'(cfg_out), 32'd0);
    tick();
    chk("rl_done", 32'(cfg_done), 32'd1);
    chk("rl_out", 32'(cfg_out), 32'h0000FFB2);
    tick();
    chk("rl_busy", 32'(cfg_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cfg_chain_loader.md
Name: cfg_chain_loader

Overview:
- Parametrised successor to the single 64-bit programming chain.
- Shifts a bitstream into NUM_CHAINS parallel configuration chains of CHAIN_LEN bits each, under a valid/ready handshake on prog_clk.
- Counts accepted beats and commits the full image to a shadow register driving the fabric, so config bits never glitch mid-load.
- Passes shifted-out bits to a downstream chain segment; sits between the bitstream source and the fabric config latches.

Parameters:
- NUM_CHAINS, 4, number of parallel chains; one head bit per chain per beat.
- CHAIN_LEN, 64, bits per chain; must be ≥ 2.
- CNT_W, $clog2(CHAIN_LEN), beat counter width (derived; minimum 1).

Ports:
- prog_clk  in  1  programming clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- cfg_start  in  1  begin a load; sampled only in IDLE.
- cfg_abort  in  1  abandon the load in progress; no commit.
- fpga_head  in  NUM_CHAINS  head bit per chain.
- head_valid  in  1  fpga_head is valid this cycle.
- head_ready  out  1  block accepts a beat this cycle.
- fpga_tail  out  NUM_CHAINS  bits shifted out of each chain MSB, registered.
- tail_valid  out  1  fpga_tail is new this cycle.
- cfg_busy  out  1  high in SHIFT and COMMIT.
- cfg_done  out  1  one-cycle pulse; coincides with the first cycle of new cfg_out.
- cfg_out  out  NUM_CHAINS*CHAIN_LEN  committed config; chain c occupies bits [c*CHAIN_LEN +: CHAIN_LEN].

Behaviour:
- Reset: all outputs and registers go to 0 (shift, shadow, counter, fpga_tail, tail_valid, cfg_done); state = IDLE. Reset takes priority in every state; a load interrupted by reset never commits.
- States: IDLE, SHIFT, COMMIT.
- IDLE:
  - head_ready = 0.
  - cfg_start = 1 and cfg_abort = 0 → SHIFT, counter = 0.
  - cfg_start with cfg_abort both high → stay in IDLE.
- SHIFT:
  - head_ready = 1 combinationally.
  - Beat accepted when head_valid & head_ready. Per accepted beat, chain c: shift_c <= {shift_c[CHAIN_LEN-2:0], fpga_head[c]}; fpga_tail[c] <= shift_c[CHAIN_LEN-1] (pre-shift value); tail_valid <= 1; counter++.
  - No accepted beat → shift, counter and fpga_tail hold; tail_valid <= 0.
  - Accepted beat with counter == CHAIN_LEN-1 → COMMIT; counter wraps to 0.
  - cfg_abort → IDLE. An abort beat is not accepted: cfg_abort forces head_ready = 0. Shift contents are retained; shadow is untouched.
  - cfg_start is ignored in SHIFT.
- COMMIT:
  - Lasts one cycle; head_ready = 0; cfg_abort ignored.
  - At the edge: shadow <= shift, cfg_done <= 1, state → IDLE.
  - cfg_out and cfg_done therefore change in the same cycle.
- The first bit fed to a chain ends in its MSB after CHAIN_LEN beats.
- Latency: fpga_tail and tail_valid appear 1 cycle after the accepted beat. cfg_out updates 2 cycles after the final beat.
- A back-to-back cfg_start in the cfg_done cycle is accepted (IDLE).

Optional Feature:
- Macro: CFG_CHAIN_CRC_EN.
- With the macro defined:
  - Adds output crc_out[15:0]: CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first, no final XOR).
  - Covers every accepted bit, processed chain 0 first within a beat.
  - Re-initialised to 0xFFFF on reset and on the IDLE→SHIFT transition.
  - Frozen (holds) in IDLE after commit or abort.
- Without the macro: port and logic are absent; everything else is identical.

Decomposition:
- Package cfg_chain_pkg: state enum (IDLE/SHIFT/COMMIT), CRC_POLY = 16'h1021, CRC_INIT = 16'hFFFF.
- Sub-module cfg_chain_lane: one chain's shift register, shadow register and tail flop. Enables: shift_en, commit_en. Instantiated NUM_CHAINS times via generate. FSM, counter and CRC stay in the top.

Test Plan (NUM_CHAINS=2, CHAIN_LEN=8):
- Full load, head_valid always high → 8 beats; chain0 fed 1,0,1,1,0,0,1,0 and chain1 fed all ones → cfg_done pulse 2 cycles after the last beat; cfg_out[7:0] = 8'hB2, cfg_out[15:8] = 8'hFF; cfg_busy low after the cfg_done cycle.
- Second load of all zeros after the first → fpga_tail beats reproduce 1,0,1,1,0,0,1,0 on bit 0 and ones on bit 1, each with tail_valid 1 cycle after its beat; final cfg_out = 0.
- head_valid toggling every other cycle → exactly 8 accepted beats; cfg_out identical to the first test; tail_valid only on the cycle after each accepted beat.
- cfg_abort after beat 5 → state IDLE, no cfg_done, cfg_out unchanged; cfg_start and cfg_abort together in IDLE → remains IDLE.
- reset asserted at beat 4 → all outputs 0 next cycle, including cfg_out and fpga_tail; a subsequent full load completes normally.
- With CFG_CHAIN_CRC_EN, single chain of all-zero bits, 8 beats → crc_out = CRC-16-CCITT of 0x00 from 0xFFFF = 0xE1F0.
